mlp_input_sequencer: RTL and testbench
======================================

MLP_INPUT_SEQUENCER -- requirements
Module: mlp_input_sequencer

Interface
REQ-001 Parameter DATA_WIDTH, default 32: width of an MLP input word.
REQ-002 Parameter ADDR_WIDTH, default 10: word-index width per bank; max N = 2**ADDR_WIDTH.
REQ-003 Parameter CNT_WIDTH, default 16: width of the sample counter.
REQ-004 pi_clk  in  1  single clock for all logic.
REQ-005 pi_rst  in  1  asynchronous, active-high reset.
REQ-006 pi_start  in  1  one-cycle request to begin a run; honoured only in IDLE.
REQ-007 pi_abort  in  1  terminates the run; checked every cycle.
REQ-008 pi_num_inputs  in  ADDR_WIDTH+1  words per sample N; legal range 1..2**ADDR_WIDTH.
REQ-009 pi_num_samples  in  CNT_WIDTH  samples per run S; legal range 1..2**CNT_WIDTH-1.
REQ-010 pi_mlp_data_valid  in  1  a word is available from axis_slave.
REQ-011 pi_mlp_data  in  DATA_WIDTH  word from axis_slave.
REQ-012 po_data_read  out  1  pop strobe to axis_slave pi_data_read.
REQ-013 po_buf_we  out  1  input-buffer write enable.
REQ-014 po_buf_addr  out  ADDR_WIDTH+1  buffer address; MSB = bank, LSBs = word index.
REQ-015 po_buf_wdata  out  DATA_WIDTH  buffer write data.
REQ-016 po_sample_valid  out  1  one-cycle pulse: bank po_sample_bank holds a complete sample.
REQ-017 po_sample_bank  out  1  bank identifier qualified by po_sample_valid.
REQ-018 pi_bank_release  in  1  one-cycle pulse: the MLP has finished with bank pi_release_bank.
REQ-019 pi_release_bank  in  1  bank being released.
REQ-020 po_busy  out  1  high in every state except IDLE.
REQ-021 po_done  out  1  one-cycle pulse when all S samples are published.
REQ-022 po_cfg_err  out  1  one-cycle pulse when pi_start is rejected for illegal N or S.

Function
REQ-023 States: IDLE, FILL, PUBLISH, WAIT_BANK, DONE.
REQ-024 IDLE: on pi_start with legal N and S, latch N and S, set sample count to 0 and fill bank to 0, then go to FILL; with illegal N or S, pulse po_cfg_err and stay in IDLE.
REQ-025 po_data_read is combinational and equals (state==FILL) & pi_mlp_data_valid & ~pi_abort; at most one pop per cycle.
REQ-026 Each pop registers a buffer write one cycle later: po_buf_we=1, po_buf_addr={fill bank, word index}, po_buf_wdata = the popped word.
REQ-027 The word index starts at 0 and increments per pop; the pop with index N-1 moves the FSM to PUBLISH and resets the index to 0.
REQ-028 PUBLISH (one cycle, aligned with the final buffer write): pulse po_sample_valid with po_sample_bank set to the fill bank, mark that bank full, and increment the sample count.
REQ-029 After PUBLISH: if the count equals S, go to DONE; otherwise toggle the fill bank and go to FILL if the new bank is free, or to WAIT_BANK if it is full.
REQ-030 WAIT_BANK: no pops; go to FILL when the fill bank becomes free.
REQ-031 DONE: pulse po_done for one cycle, then go to IDLE; the full flags persist until released.
REQ-032 pi_bank_release clears the full flag of pi_release_bank; releasing a bank that is not full has no effect.
REQ-033 If a release and a publish target the same bank in the same cycle, the publish wins and the bank stays full.
REQ-034 A release in WAIT_BANK is honoured the same cycle, and FILL begins on the next cycle.
REQ-035 pi_abort in any non-IDLE state: go to IDLE next cycle, suppress any pending buffer write and publish, and clear both full flags; pi_start arriving with pi_abort is ignored.
REQ-036 pi_start outside IDLE is ignored, and N and S are not re-latched.
REQ-037 With N=1, consecutive pops alternate FILL and PUBLISH.

Reset
REQ-038 On pi_rst: state=IDLE, index=0, count=0, fill bank=0, both banks free, and all outputs 0.
REQ-039 Reset mid-run discards all progress; no partial-sample pulse is emitted after deassertion.

Structure
REQ-040 Package mlp_seq_pkg holds the state enum and the default values of DATA_WIDTH, ADDR_WIDTH and CNT_WIDTH.
REQ-041 Sub-module mlp_bank_tracker holds the two full flags and implements the publish/release/abort priority of REQ-032, REQ-033 and REQ-035.

Verification
REQ-042 N=4, S=2, valid held high, release each bank 3 cycles after its publish -> writes to addr 0..3 then 1024..1027, po_sample_valid with bank 0 then bank 1, then po_done.
REQ-043 N=2, S=3, no releases -> after 2 samples the FSM is in WAIT_BANK with po_data_read=0; releasing bank 0 -> the third sample is written to addr 0..1.
REQ-044 Start with N=0 or S=0 -> po_cfg_err pulses once, po_busy stays 0, no pops.
REQ-045 N=8, abort after 5 pops -> no publish, po_busy falls next cycle, a restart writes from addr 0.
REQ-046 Release bank 0 in the same cycle bank 0 is published -> bank 0 remains full.
REQ-047 N=1, S=4, valid toggling every cycle -> 4 publishes alternating banks 0,1,0,1 with releases given, and exactly 4 pops.

Source files
------------

// File: rtl/mlp_seq_pkg.sv
// Shared definitions for the MLP input sequencer: default widths and FSM state encodings.
package mlp_seq_pkg;

  localparam int DEFAULT_DATA_WIDTH = 32;
  localparam int DEFAULT_ADDR_WIDTH = 10;
  localparam int DEFAULT_CNT_WIDTH  = 16;

  typedef logic [2:0] state_t;

  localparam state_t ST_IDLE      = 3'd0;
  localparam state_t ST_FILL      = 3'd1;
  localparam state_t ST_PUBLISH   = 3'd2;
  localparam state_t ST_WAIT_BANK = 3'd3;
  localparam state_t ST_DONE      = 3'd4;

endpackage

// File: rtl/mlp_bank_tracker.sv
// Full flags for the two ping-pong input banks.
// Abort clears everything; a publish beats a release aimed at the same bank.
module mlp_bank_tracker
  import mlp_seq_pkg::*;
(
  input  logic       clk,
  input  logic       rst,
  input  logic       publish,
  input  logic       publish_bank,
  input  logic       bank_release,
  input  logic       release_bank,
  input  logic       clear,
  output logic [1:0] full
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      full <= 2'b00;
    end else if (clear) begin
      full <= 2'b00;
    end else begin
      for (int b = 0; b < 2; b++) begin
        if (publish && (publish_bank == 1'(b))) begin
          full[b] <= 1'b1;
        end else if (bank_release && (release_bank == 1'(b))) begin
          full[b] <= 1'b0;
        end
      end
    end
  end

endmodule

// File: rtl/mlp_input_sequencer.sv
// Pops MLP input words from the stream, writes them into a double-buffered input memory
// and publishes each completed bank to the MLP, stalling when both banks are in use.
module mlp_input_sequencer
  import mlp_seq_pkg::*;
#(
  parameter int DATA_WIDTH = DEFAULT_DATA_WIDTH,
  parameter int ADDR_WIDTH = DEFAULT_ADDR_WIDTH,
  parameter int CNT_WIDTH  = DEFAULT_CNT_WIDTH
) (
  input  logic                  pi_clk,
  input  logic                  pi_rst,
  input  logic                  pi_start,
  input  logic                  pi_abort,
  input  logic [ADDR_WIDTH:0]   pi_num_inputs,
  input  logic [CNT_WIDTH-1:0]  pi_num_samples,
  input  logic                  pi_mlp_data_valid,
  input  logic [DATA_WIDTH-1:0] pi_mlp_data,
  output logic                  po_data_read,
  output logic                  po_buf_we,
  output logic [ADDR_WIDTH:0]   po_buf_addr,
  output logic [DATA_WIDTH-1:0] po_buf_wdata,
  output logic                  po_sample_valid,
  output logic                  po_sample_bank,
  input  logic                  pi_bank_release,
  input  logic                  pi_release_bank,
  output logic                  po_busy,
  output logic                  po_done,
  output logic                  po_cfg_err
);

  localparam logic [ADDR_WIDTH:0] MAX_INPUTS = {1'b1, {ADDR_WIDTH{1'b0}}};

  state_t                  state;
  logic [ADDR_WIDTH-1:0]   word_idx;
  logic [ADDR_WIDTH:0]     num_inputs;
  logic [CNT_WIDTH-1:0]    num_samples;
  logic [CNT_WIDTH-1:0]    sample_cnt;
  logic                    fill_bank;
  logic                    we_q;
  logic [ADDR_WIDTH:0]     addr_q;
  logic [DATA_WIDTH-1:0]   wdata_q;
  logic [1:0]              bank_full;

  logic                    cfg_ok;
  logic                    start_req;
  logic                    pop;
  logic                    last_word;
  logic                    publish;
  logic                    abort_run;
  logic [CNT_WIDTH-1:0]    count_next;
  logic                    next_bank;
  logic                    next_bank_free;
  logic                    fill_bank_free;

  assign cfg_ok     = (pi_num_inputs != '0) && (pi_num_inputs <= MAX_INPUTS) && (pi_num_samples != '0);
  assign start_req  = (state == ST_IDLE) && pi_start && !pi_abort;
  assign pop        = (state == ST_FILL) && pi_mlp_data_valid && !pi_abort;
  assign last_word  = ({1'b0, word_idx} == (num_inputs - (ADDR_WIDTH+1)'(1)));
  assign publish    = (state == ST_PUBLISH) && !pi_abort;
  assign abort_run  = pi_abort && (state != ST_IDLE);
  assign count_next = sample_cnt + CNT_WIDTH'(1);
  assign next_bank  = ~fill_bank;

  // A release arriving in the same cycle counts as the bank already being free.
  assign next_bank_free = !bank_full[next_bank] || (pi_bank_release && (pi_release_bank == next_bank));
  assign fill_bank_free = !bank_full[fill_bank] || (pi_bank_release && (pi_release_bank == fill_bank));

  assign po_data_read    = pop;
  assign po_buf_we       = we_q && !pi_abort;
  assign po_buf_addr     = addr_q;
  assign po_buf_wdata    = wdata_q;
  assign po_sample_valid = publish;
  assign po_sample_bank  = fill_bank;
  assign po_busy         = (state != ST_IDLE);
  assign po_done         = (state == ST_DONE);
  assign po_cfg_err      = start_req && !cfg_ok;

  always_ff @(posedge pi_clk or posedge pi_rst) begin
    if (pi_rst) begin
      state       <= ST_IDLE;
      word_idx    <= '0;
      num_inputs  <= '0;
      num_samples <= '0;
      sample_cnt  <= '0;
      fill_bank   <= 1'b0;
      we_q        <= 1'b0;
      addr_q      <= '0;
      wdata_q     <= '0;
    end else begin
      we_q <= pop;
      if (pop) begin
        addr_q  <= {fill_bank, word_idx};
        wdata_q <= pi_mlp_data;
      end
      if (abort_run) begin
        state    <= ST_IDLE;
        word_idx <= '0;
      end else begin
        case (state)
          ST_IDLE: begin
            if (start_req && cfg_ok) begin
              num_inputs  <= pi_num_inputs;
              num_samples <= pi_num_samples;
              sample_cnt  <= '0;
              fill_bank   <= 1'b0;
              word_idx    <= '0;
              state       <= ST_FILL;
            end
          end
          ST_FILL: begin
            if (pop) begin
              if (last_word) begin
                word_idx <= '0;
                state    <= ST_PUBLISH;
              end else begin
                word_idx <= word_idx + ADDR_WIDTH'(1);
              end
            end
          end
          ST_PUBLISH: begin
            sample_cnt <= count_next;
            if (count_next == num_samples) begin
              state <= ST_DONE;
            end else begin
              fill_bank <= next_bank;
              state     <= next_bank_free ? ST_FILL : ST_WAIT_BANK;
            end
          end
          ST_WAIT_BANK: begin
            if (fill_bank_free) begin
              state <= ST_FILL;
            end
          end
          ST_DONE: state <= ST_IDLE;
          default: state <= ST_IDLE;
        endcase
      end
    end
  end

  mlp_bank_tracker u_bank_tracker (
    .clk          (pi_clk),
    .rst          (pi_rst),
    .publish      (publish),
    .publish_bank (fill_bank),
    .bank_release (pi_bank_release),
    .release_bank (pi_release_bank),
    .clear        (abort_run),
    .full         (bank_full)
  );

endmodule

// File: tb/tb_mlp_input_sequencer.sv
// Directed bench for the MLP input sequencer: a word source that advances on each pop,
// an event logger, an optional automatic bank releaser and hand-computed expectations.
module tb_mlp_input_sequencer;

  localparam int DW = 32;
  localparam int AW = 10;
  localparam int CW = 16;
  localparam logic [DW-1:0] DATA_BASE = 32'hD000_0000;

  logic          clk = 1'b0;
  logic          rst;
  logic          pi_start;
  logic          pi_abort;
  logic [AW:0]   pi_num_inputs;
  logic [CW-1:0] pi_num_samples;
  logic          pi_mlp_data_valid;
  logic [DW-1:0] pi_mlp_data;
  logic          po_data_read;
  logic          po_buf_we;
  logic [AW:0]   po_buf_addr;
  logic [DW-1:0] po_buf_wdata;
  logic          po_sample_valid;
  logic          po_sample_bank;
  logic          pi_bank_release;
  logic          pi_release_bank;
  logic          po_busy;
  logic          po_done;
  logic          po_cfg_err;

  logic man_rel = 1'b0;
  logic man_bank = 1'b0;
  logic auto_rel = 1'b0;
  logic auto_bank = 1'b0;
  logic auto_en = 1'b0;

  int fifo_idx = 0;
  int done_cnt = 0;
  int cfg_cnt = 0;
  int rel_cnt[2] = '{0, 0};
  logic [AW:0]   wr_addr_q[$];
  logic [DW-1:0] wr_data_q[$];
  logic          pub_q[$];

  int assertions = 0;
  int failures = 0;

  always #5 clk = ~clk;

  assign pi_mlp_data     = DATA_BASE + DW'(fifo_idx);
  assign pi_bank_release = man_rel | auto_rel;
  assign pi_release_bank = auto_rel ? auto_bank : man_bank;

  mlp_input_sequencer dut (
    .pi_clk            (clk),
    .pi_rst            (rst),
    .pi_start          (pi_start),
    .pi_abort          (pi_abort),
    .pi_num_inputs     (pi_num_inputs),
    .pi_num_samples    (pi_num_samples),
    .pi_mlp_data_valid (pi_mlp_data_valid),
    .pi_mlp_data       (pi_mlp_data),
    .po_data_read      (po_data_read),
    .po_buf_we         (po_buf_we),
    .po_buf_addr       (po_buf_addr),
    .po_buf_wdata      (po_buf_wdata),
    .po_sample_valid   (po_sample_valid),
    .po_sample_bank    (po_sample_bank),
    .pi_bank_release   (pi_bank_release),
    .pi_release_bank   (pi_release_bank),
    .po_busy           (po_busy),
    .po_done           (po_done),
    .po_cfg_err        (po_cfg_err)
  );

  // The word source presents the next word and moves on whenever the sequencer pops.
  always @(posedge clk) begin
    if (po_data_read) fifo_idx <= fifo_idx + 1;
  end

  // Event logger and automatic releaser: a published bank is released three cycles later.
  always @(negedge clk) begin
    if (po_buf_we) begin
      wr_addr_q.push_back(po_buf_addr);
      wr_data_q.push_back(po_buf_wdata);
    end
    if (po_sample_valid) pub_q.push_back(po_sample_bank);
    if (po_done) done_cnt++;
    if (po_cfg_err) cfg_cnt++;
    auto_rel = 1'b0;
    for (int b = 0; b < 2; b++) begin
      if (rel_cnt[b] > 0) begin
        rel_cnt[b]--;
        if (rel_cnt[b] == 0) begin
          auto_rel  = 1'b1;
          auto_bank = 1'(b);
        end
      end
    end
    if (po_sample_valid && auto_en) rel_cnt[po_sample_bank] = 3;
  end

  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: simulation time limit reached, got running expected finished");
    $fatal(1, "[TB] watchdog expired");
  end

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    assertions++;
    if (observed !== expected) begin
      failures++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic applyStimulus(input int n, input int s);
    pi_num_inputs  = (AW+1)'(n);
    pi_num_samples = CW'(s);
    pi_start       = 1'b1;
    tick();
    pi_start       = 1'b0;
  endtask

  task automatic doReset(input string tag);
    rst = 1'b1;
    pi_start = 1'b0;
    pi_abort = 1'b0;
    pi_mlp_data_valid = 1'b1;
    man_rel = 1'b0;
    repeat (2) tick();
    checkOutput({tag, "_rst_busy"}, 64'(po_busy), 64'd0);
    checkOutput({tag, "_rst_we"}, 64'(po_buf_we), 64'd0);
    checkOutput({tag, "_rst_addr"}, 64'(po_buf_addr), 64'd0);
    checkOutput({tag, "_rst_read"}, 64'(po_data_read), 64'd0);
    checkOutput({tag, "_rst_svalid"}, 64'(po_sample_valid), 64'd0);
    checkOutput({tag, "_rst_done"}, 64'(po_done), 64'd0);
    rst = 1'b0;
    pi_mlp_data_valid = 1'b0;
    tick();
  endtask

  task automatic waitDone(input int budget, input string tag);
    int start_cnt = done_cnt;
    int n = 0;
    while (done_cnt == start_cnt && n < budget) begin
      tick();
      n++;
    end
    checkOutput({tag, "_done_seen"}, 64'(done_cnt - start_cnt), 64'd1);
  endtask

  function automatic logic [63:0] wrAddrAt(input int i);
    if (i < wr_addr_q.size()) return 64'(wr_addr_q[i]);
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] wrDataAt(input int i);
    if (i < wr_data_q.size()) return 64'(wr_data_q[i]);
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  function automatic logic [63:0] pubAt(input int i);
    if (i < pub_q.size()) return 64'(pub_q[i]);
    return 64'hFFFF_FFFF_FFFF_FFFF;
  endfunction

  initial begin
    int wb, pb, fb, cb, n;
    logic [AW:0] exp_addr[$];
    logic [AW:0] t2_addr[6];
    logic t6_bank[4];

    rst = 1'b1;
    pi_start = 1'b0;
    pi_abort = 1'b0;
    pi_num_inputs = '0;
    pi_num_samples = '0;
    pi_mlp_data_valid = 1'b0;

    // Two samples of four words, valid held high, auto release.
    doReset("t1");
    auto_en = 1'b1;
    pi_mlp_data_valid = 1'b1;
    wb = wr_addr_q.size(); pb = pub_q.size(); fb = fifo_idx;
    applyStimulus(4, 2);
    waitDone(60, "t1");
    repeat (6) tick();
    checkOutput("t1_nwrites", 64'(wr_addr_q.size() - wb), 64'd8);
    for (int i = 0; i < 8; i++) begin
      checkOutput($sformatf("t1_addr%0d", i), wrAddrAt(wb + i), (i < 4) ? 64'(i) : 64'(1024 + i - 4));
      checkOutput($sformatf("t1_data%0d", i), wrDataAt(wb + i), 64'(DATA_BASE + DW'(fb + i)));
    end
    checkOutput("t1_npubs", 64'(pub_q.size() - pb), 64'd2);
    checkOutput("t1_pub0", pubAt(pb), 64'd0);
    checkOutput("t1_pub1", pubAt(pb + 1), 64'd1);
    checkOutput("t1_pops", 64'(fifo_idx - fb), 64'd8);
    checkOutput("t1_idle", 64'(po_busy), 64'd0);

    // Three samples of two words with no releases: stall in WAIT_BANK, then release bank 0.
    doReset("t2");
    auto_en = 1'b0;
    pi_mlp_data_valid = 1'b1;
    wb = wr_addr_q.size(); pb = pub_q.size(); fb = fifo_idx;
    applyStimulus(2, 3);
    n = 0;
    while ((pub_q.size() - pb) < 2 && n < 40) begin
      tick();
      n++;
    end
    repeat (3) tick();
    checkOutput("t2_stall_read", 64'(po_data_read), 64'd0);
    checkOutput("t2_stall_busy", 64'(po_busy), 64'd1);
    checkOutput("t2_stall_pops", 64'(fifo_idx - fb), 64'd4);
    pi_num_inputs = (AW+1)'(1);
    pi_num_samples = CW'(1);
    pi_start = 1'b1;
    tick();
    pi_start = 1'b0;
    man_bank = 1'b0;
    man_rel = 1'b1;
    tick();
    man_rel = 1'b0;
    waitDone(40, "t2");
    t2_addr = '{11'd0, 11'd1, 11'd1024, 11'd1025, 11'd0, 11'd1};
    checkOutput("t2_nwrites", 64'(wr_addr_q.size() - wb), 64'd6);
    for (int i = 0; i < 6; i++) begin
      checkOutput($sformatf("t2_addr%0d", i), wrAddrAt(wb + i), 64'(t2_addr[i]));
      checkOutput($sformatf("t2_data%0d", i), wrDataAt(wb + i), 64'(DATA_BASE + DW'(fb + i)));
    end
    checkOutput("t2_npubs", 64'(pub_q.size() - pb), 64'd3);
    checkOutput("t2_pub2", pubAt(pb + 2), 64'd0);

    // Illegal configurations are rejected with one error pulse each.
    doReset("t3");
    pi_mlp_data_valid = 1'b1;
    cb = cfg_cnt; fb = fifo_idx;
    applyStimulus(0, 5);
    checkOutput("t3_err_n0", 64'(cfg_cnt - cb), 64'd1);
    checkOutput("t3_busy_n0", 64'(po_busy), 64'd0);
    applyStimulus(4, 0);
    checkOutput("t3_err_s0", 64'(cfg_cnt - cb), 64'd2);
    applyStimulus(1025, 1);
    checkOutput("t3_err_nbig", 64'(cfg_cnt - cb), 64'd3);
    repeat (3) tick();
    checkOutput("t3_busy_end", 64'(po_busy), 64'd0);
    checkOutput("t3_pops", 64'(fifo_idx - fb), 64'd0);

    // Abort after five pops of an eight-word sample, then restart from address 0.
    doReset("t4");
    auto_en = 1'b1;
    pi_mlp_data_valid = 1'b1;
    wb = wr_addr_q.size(); pb = pub_q.size(); fb = fifo_idx;
    applyStimulus(8, 1);
    n = 0;
    while ((fifo_idx - fb) < 5 && n < 30) begin
      tick();
      n++;
    end
    pi_abort = 1'b1;
    #1;
    checkOutput("t4_abort_read", 64'(po_data_read), 64'd0);
    checkOutput("t4_abort_we", 64'(po_buf_we), 64'd0);
    tick();
    pi_abort = 1'b0;
    checkOutput("t4_busy_fall", 64'(po_busy), 64'd0);
    checkOutput("t4_nwrites", 64'(wr_addr_q.size() - wb), 64'd4);
    checkOutput("t4_pops", 64'(fifo_idx - fb), 64'd5);
    checkOutput("t4_npubs", 64'(pub_q.size() - pb), 64'd0);
    wb = wr_addr_q.size();
    applyStimulus(2, 1);
    waitDone(30, "t4");
    checkOutput("t4_re_addr0", wrAddrAt(wb), 64'd0);
    checkOutput("t4_re_data0", wrDataAt(wb), 64'(DATA_BASE + DW'(fb + 5)));
    checkOutput("t4_re_addr1", wrAddrAt(wb + 1), 64'd1);
    checkOutput("t4_re_data1", wrDataAt(wb + 1), 64'(DATA_BASE + DW'(fb + 6)));
    repeat (6) tick();

    // Release of bank 0 in its own publish cycle loses: bank 0 stays full and blocks sample 3.
    doReset("t5");
    auto_en = 1'b0;
    pi_mlp_data_valid = 1'b1;
    pb = pub_q.size(); fb = fifo_idx;
    applyStimulus(1, 3);
    tick();
    checkOutput("t5_pub_cycle", 64'(po_sample_valid), 64'd1);
    man_bank = 1'b0;
    man_rel = 1'b1;
    tick();
    man_rel = 1'b0;
    repeat (8) tick();
    checkOutput("t5_npubs", 64'(pub_q.size() - pb), 64'd2);
    checkOutput("t5_pops", 64'(fifo_idx - fb), 64'd2);
    checkOutput("t5_busy", 64'(po_busy), 64'd1);
    checkOutput("t5_read", 64'(po_data_read), 64'd0);

    // One-word samples with valid toggling every cycle alternate banks 0,1,0,1.
    doReset("t6");
    auto_en = 1'b1;
    pi_mlp_data_valid = 1'b0;
    wb = wr_addr_q.size(); pb = pub_q.size(); fb = fifo_idx; cb = done_cnt;
    applyStimulus(1, 4);
    n = 0;
    while (done_cnt == cb && n < 100) begin
      pi_mlp_data_valid = ~pi_mlp_data_valid;
      tick();
      n++;
    end
    checkOutput("t6_done_seen", 64'(done_cnt - cb), 64'd1);
    pi_mlp_data_valid = 1'b1;
    repeat (6) tick();
    t6_bank = '{1'b0, 1'b1, 1'b0, 1'b1};
    checkOutput("t6_npubs", 64'(pub_q.size() - pb), 64'd4);
    checkOutput("t6_pops", 64'(fifo_idx - fb), 64'd4);
    for (int i = 0; i < 4; i++) begin
      checkOutput($sformatf("t6_pub%0d", i), pubAt(pb + i), 64'(t6_bank[i]));
      checkOutput($sformatf("t6_addr%0d", i), wrAddrAt(wb + i), t6_bank[i] ? 64'd1024 : 64'd0);
      checkOutput($sformatf("t6_data%0d", i), wrDataAt(wb + i), 64'(DATA_BASE + DW'(fb + i)));
    end

    // Reset in the middle of a sample leaves no trace once released.
    doReset("t7");
    auto_en = 1'b0;
    pi_mlp_data_valid = 1'b1;
    applyStimulus(4, 1);
    repeat (2) tick();
    rst = 1'b1;
    tick();
    rst = 1'b0;
    wb = wr_addr_q.size(); pb = pub_q.size();
    repeat (8) tick();
    checkOutput("t7_nwrites", 64'(wr_addr_q.size() - wb), 64'd0);
    checkOutput("t7_npubs", 64'(pub_q.size() - pb), 64'd0);
    checkOutput("t7_busy", 64'(po_busy), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", assertions, failures);
    $finish;
  end

endmodule
